axi_mem_responder: RTL and testbench



---
 rtl/axi_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI slave memory model: single-beat 128-bit R/W, in-order R and B responses with original IDs.
// rvalid RD_LAT+1 cycles after AR, bvalid 2 cycles after AW+W; ready drops only when its queue holds QDEPTH.
module axi_mem_responder_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [PW:0]   CONE    = 1;
  localparam logic [PW-1:0] PONE    = 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop)  rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  assign head_dat = store[rd_ptr];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
endmodule

module axi_mem_responder #(
  parameter int          ID_WIDTH  = 8,
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          QDEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [127:0]        rdata,
  output logic [ID_WIDTH-1:0] rid,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [127:0]        wdata,
  input  logic [15:0]         wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp
);
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [MEM_AW-1:0]   idx;
    logic                err;
  } req_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  strb;
  } wbeat_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } bent_t;

  localparam logic [28:0] BASE_W = {1'b0, BASE_ADDR[31:4]};
  localparam logic [3:0]  LAT_C  = RD_LAT[3:0];
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  // Word-granular offset; a borrow into bit 28 means the address is below the base.
  function automatic req_t decode(input logic [ID_WIDTH-1:0] id, input logic [27:0] word);
    req_t        r;
    logic [28:0] off;
    off   = {1'b0, word} - BASE_W;
    r.id  = id;
    r.idx = off[MEM_AW-1:0];
    r.err = off[28] || (off[27:0] >= (28'd1 << MEM_AW));
    return r;
  endfunction

  logic [127:0] mem [2**MEM_AW];

  logic   ar_push, ar_pop, ar_full, ar_empty;
  logic   aw_push, aw_full, aw_empty;
  logic   w_push, w_full, w_empty;
  logic   b_full, b_empty, b_pop, b_load;
  logic   commit, r_load;
  req_t   ar_head, aw_head;
  wbeat_t w_head;
  bent_t  b_head;
  logic [3:0] lat;
  logic   unused_addr_lsbs;

  assign unused_addr_lsbs = ^{araddr[3:0], awaddr[3:0]};

  assign arready = !ar_full;
  assign awready = !aw_full;
  assign wready  = !w_full;
  assign rlast   = 1'b1;

  assign ar_push = arvalid && arready;
  assign aw_push = awvalid && awready;
  assign w_push  = wvalid && wready;
  assign ar_pop  = rvalid && rready;
  assign commit  = !aw_empty && !w_empty && !b_full;
  assign b_pop   = bvalid && bready;
  assign r_load  = !ar_empty && !rvalid && (lat == LAT_C);
  assign b_load  = !b_empty && !bvalid;

  axi_mem_responder_fifo #(.W($bits(req_t)), .DEPTH(QDEPTH)) u_ar_q (
    .clk(clk), .reset_l(reset_l),
    .push(ar_push), .push_dat(decode(arid, araddr[31:4])),
    .pop(ar_pop), .head_dat(ar_head), .full(ar_full), .empty(ar_empty)
  );

  axi_mem_responder_fifo #(.W($bits(req_t)), .DEPTH(QDEPTH)) u_aw_q (
    .clk(clk), .reset_l(reset_l),
    .push(aw_push), .push_dat(decode(awid, awaddr[31:4])),
    .pop(commit), .head_dat(aw_head), .full(aw_full), .empty(aw_empty)
  );

  axi_mem_responder_fifo #(.W($bits(wbeat_t)), .DEPTH(QDEPTH)) u_w_q (
    .clk(clk), .reset_l(reset_l),
    .push(w_push), .push_dat({wdata, wstrb}),
    .pop(commit), .head_dat(w_head), .full(w_full), .empty(w_empty)
  );

  axi_mem_responder_fifo #(.W($bits(bent_t)), .DEPTH(QDEPTH)) u_b_q (
    .clk(clk), .reset_l(reset_l),
    .push(commit), .push_dat({aw_head.id, aw_head.err ? SLVERR : OKAY}),
    .pop(b_pop), .head_dat(b_head), .full(b_full), .empty(b_empty)
  );

  always_ff @(posedge clk) begin
    if (commit && !aw_head.err) begin
      for (int i = 0; i < 16; i++) begin
        if (w_head.strb[i]) mem[aw_head.idx][8*i +: 8] <= w_head.data[8*i +: 8];
      end
    end
  end

  // Aging restarts whenever the queue is empty or the head pops, i.e. each new head starts at zero.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lat    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
      rresp  <= OKAY;
    end else begin
      if (ar_pop || ar_empty) lat <= '0;
      else if (lat < LAT_C)   lat <= lat + 4'd1;

      if (ar_pop) begin
        rvalid <= 1'b0;
      end else if (r_load) begin
        rvalid <= 1'b1;
        rdata  <= ar_head.err ? '0 : mem[ar_head.idx];
        rid    <= ar_head.id;
        rresp  <= ar_head.err ? SLVERR : OKAY;
      end
    end
  end

  // B head is presented from a register; the queue entry pops on handshake.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bvalid <= 1'b0;
      bid    <= '0;
      bresp  <= OKAY;
    end else if (b_pop) begin
      bvalid <= 1'b0;
    end else if (b_load) begin
      bvalid <= 1'b1;
      bid    <= b_head.id;
      bresp  <= b_head.resp;
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: random traffic against a word-array reference model,
// plus directed latency, back-pressure, out-of-range and mid-flight reset scenarios.
`timescale 1ns/1ps
module tb_axi_mem_responder;
  localparam int          IDW   = 8;
  localparam int          MAW   = 6;
  localparam int          LAT   = 2;
  localparam int          QD    = 4;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WORDS = 1 << MAW;

  logic           clk = 1'b0;
  logic           reset_l = 1'b0;
  logic           arvalid = 1'b0, arready;
  logic [IDW-1:0] arid = '0;
  logic [31:0]    araddr = '0;
  logic           rvalid, rready = 1'b0;
  logic [127:0]   rdata;
  logic [IDW-1:0] rid;
  logic [1:0]     rresp;
  logic           rlast;
  logic           awvalid = 1'b0, awready;
  logic [IDW-1:0] awid = '0;
  logic [31:0]    awaddr = '0;
  logic           wvalid = 1'b0, wready;
  logic [127:0]   wdata = '0;
  logic [15:0]    wstrb = '0;
  logic           bvalid, bready = 1'b0;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] model_mem [WORDS];

  always #5 clk = ~clk;

  axi_mem_responder #(.ID_WIDTH(IDW), .MEM_AW(MAW), .BASE_ADDR(BASE), .RD_LAT(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .reset_l(reset_l),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'(16 * WORDS));
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a - BASE) >> 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    return BASE + 32'(16 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 15));
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [15:0] s);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] expect_rdata(input logic [31:0] a);
    return addr_err(a) ? 128'd0 : model_mem[addr_idx(a)];
  endfunction

  task automatic send_write(input logic [31:0] a, input logic [IDW-1:0] id, input logic [127:0] d, input logic [15:0] s);
    bit aw_done, w_done;
    aw_done = 0; w_done = 0;
    awvalid = 1; awaddr = a; awid = id;
    wvalid = 1; wdata = d; wstrb = s;
    for (int n = 0; n < 100 && !(aw_done && w_done); n++) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
    end
    if (!(aw_done && w_done)) begin
      vectors++; miscompares++;
      $display("FAIL write_accept: no AW/W handshake for addr %h (aw=%0d w=%0d), required both", a, aw_done, w_done);
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [IDW-1:0] id);
    int n;
    n = 0;
    arvalid = 1; araddr = a; arid = id;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_accept: arready stayed 0 for addr %h, required 1", a);
    end
    @(negedge clk);
    arvalid = 0;
  endtask

  task automatic get_b(output logic [IDW-1:0] id, output logic [1:0] resp);
    int n;
    n = 0;
    bready = 1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout: bvalid=0 after 50 cycles, required 1");
      id = 'x; resp = 'x;
    end else begin
      id = bid; resp = bresp;
    end
    @(negedge clk);
    bready = 0;
  endtask

  task automatic get_r(output logic [127:0] d, output logic [IDW-1:0] id, output logic [1:0] resp, output logic last);
    int n;
    n = 0;
    rready = 1;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin
      vectors++; miscompares++;
      $display("FAIL r_timeout: rvalid=0 after 50 cycles, required 1");
      d = 'x; id = 'x; resp = 'x; last = 'x;
    end else begin
      d = rdata; id = rid; resp = rresp; last = rlast;
    end
    @(negedge clk);
    rready = 0;
  endtask

  task automatic test_reset();
    reset_l = 0;
    repeat (3) @(negedge clk);
    reset_l = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b111001 || rdata !== '0 || rid !== '0 ||
          rresp !== 2'b00 || bid !== '0 || bresp !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_state c%0d: ar/aw/w_rdy,rvld,bvld,rlast=%b rdata=%h rid=%h rresp=%b bid=%h bresp=%b, required 111001 and zeros",
                 i, {arready, awready, wready, rvalid, bvalid, rlast}, rdata, rid, rresp, bid, bresp);
      end
    end
  endtask

  task automatic test_fill();
    logic [127:0] d;
    logic [IDW-1:0] id, gid;
    logic [1:0] gresp;
    for (int w = 0; w < WORDS; w++) begin
      d = rand128();
      id = IDW'($urandom);
      send_write(BASE + 32'(16 * w), id, d, 16'hFFFF);
      model_mem[w] = d;
      get_b(gid, gresp);
      vectors++;
      if (gid !== id || gresp !== 2'b00) begin
        miscompares++;
        $display("FAIL fill_b w%0d: bid=%h bresp=%b, required %h 00", w, gid, gresp, id);
      end
    end
  endtask

  task automatic test_latency();
    int k;
    awvalid = 1; awaddr = BASE + 32'h20; awid = 8'd5;
    wvalid = 1; wdata = 128'h0011_2233; wstrb = 16'h000F;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    model_mem[2] = merge(model_mem[2], 128'h0011_2233, 16'h000F);
    k = 1;
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (k !== 3) begin
      miscompares++;
      $display("FAIL b_latency: bvalid seen %0d cycles after AW/W, required 3", k);
    end
    vectors++;
    if (bid !== 8'd5 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL b_fields: bid=%h bresp=%b, required 05 00", bid, bresp);
    end
    bready = 1; @(negedge clk); bready = 0;

    arvalid = 1; araddr = BASE + 32'h20; arid = 8'd7;
    @(negedge clk);
    arvalid = 0;
    k = 1;
    while (!rvalid && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (k !== LAT + 2) begin
      miscompares++;
      $display("FAIL r_latency: rvalid seen %0d cycles after AR, required %0d", k, LAT + 2);
    end
    vectors++;
    if (rid !== 8'd7 || rresp !== 2'b00 || rdata[31:0] !== 32'h0011_2233 || rdata !== model_mem[2] || rlast !== 1'b1) begin
      miscompares++;
      $display("FAIL r_fields: rid=%h rresp=%b rlast=%b rdata=%h, required 07 00 1 %h", rid, rresp, rlast, rdata, model_mem[2]);
    end
    rready = 1; @(negedge clk); rready = 0;
  endtask

  task automatic test_w_before_aw();
    logic [127:0] wd [4];
    logic [15:0] ws [4];
    logic [31:0] wa [4];
    logic [IDW-1:0] wi [4];
    logic [IDW-1:0] gid;
    logic [1:0] gresp;
    int n;
    wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = rand128(); ws[i] = 16'($urandom);
      wdata = wd[i]; wstrb = ws[i];
      vectors++;
      if (wready !== 1'b1) begin
        miscompares++;
        $display("FAIL w_accept beat%0d: wready=%b, required 1", i, wready);
      end
      @(negedge clk);
    end
    wvalid = 0;
    vectors++;
    if (wready !== 1'b0) begin
      miscompares++;
      $display("FAIL wready_full: wready=%b after %0d W beats, required 0", wready, QD);
    end
    awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      wa[i] = rand_addr(); wi[i] = IDW'(8'h30 + i);
      awaddr = wa[i]; awid = wi[i];
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      model_mem[addr_idx(wa[i])] = merge(model_mem[addr_idx(wa[i])], wd[i], ws[i]);
      get_b(gid, gresp);
      vectors++;
      if (gid !== wi[i] || gresp !== 2'b00) begin
        miscompares++;
        $display("FAIL w_first_b%0d: bid=%h bresp=%b, required %h 00", i, gid, gresp, wi[i]);
      end
    end
    vectors++;
    if (wready !== 1'b1) begin
      miscompares++;
      $display("FAIL wready_return: wready=%b, required 1", wready);
    end
  endtask

  task automatic test_read_backpressure();
    logic [31:0] ra [6];
    logic [IDW-1:0] ri [6];
    int acc, got;
    bit hs_ar, hs_r;
    for (int i = 0; i < 6; i++) begin ra[i] = rand_addr(); ri[i] = IDW'(8'h40 + i); end
    acc = 0; got = 0;
    arvalid = 1; araddr = ra[0]; arid = ri[0];
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (c == 12) begin
        vectors++;
        if (acc !== 4 || arready !== 1'b0) begin
          miscompares++;
          $display("FAIL ar_full: accepted=%0d arready=%b, required 4 0", acc, arready);
        end
      end
      if (c >= 12 && c < 15) begin
        vectors++;
        if (rvalid !== 1'b1 || rid !== ri[0] || rdata !== expect_rdata(ra[0])) begin
          miscompares++;
          $display("FAIL r_hold c%0d: rvalid=%b rid=%h rdata=%h, required 1 %h %h", c, rvalid, rid, rdata, ri[0], expect_rdata(ra[0]));
        end
      end
      rready = (c >= 15);
      hs_ar = arvalid && arready;
      hs_r = rvalid && rready;
      if (hs_r) begin
        vectors++;
        if (rid !== ri[got] || rresp !== 2'b00 || rdata !== expect_rdata(ra[got])) begin
          miscompares++;
          $display("FAIL bp_beat%0d: rid=%h rresp=%b rdata=%h, required %h 00 %h", got, rid, rresp, rdata, ri[got], expect_rdata(ra[got]));
        end
        got++;
      end
      @(negedge clk);
      if (hs_ar) begin
        acc++;
        if (acc < 6) begin araddr = ra[acc]; arid = ri[acc]; end
        else arvalid = 0;
      end
    end
    rready = 0; arvalid = 0;
    vectors++;
    if (got !== 6 || acc !== 6) begin
      miscompares++;
      $display("FAIL bp_count: beats=%0d accepted=%0d, required 6 6", got, acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [4];
    logic [IDW-1:0] ri [4];
    int t [4];
    int acc, got;
    bit hs_ar, hs_r;
    for (int i = 0; i < 4; i++) begin ra[i] = rand_addr(); ri[i] = IDW'($urandom); end
    acc = 0; got = 0;
    rready = 1;
    arvalid = 1; araddr = ra[0]; arid = ri[0];
    for (int c = 0; c < 100 && got < 4; c++) begin
      hs_ar = arvalid && arready;
      hs_r = rvalid && rready;
      if (hs_r) begin
        vectors++;
        if (rid !== ri[got] || rdata !== expect_rdata(ra[got])) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: rid=%h rdata=%h, required %h %h", got, rid, rdata, ri[got], expect_rdata(ra[got]));
        end
        t[got] = c;
        got++;
      end
      @(negedge clk);
      if (hs_ar) begin
        acc++;
        if (acc < 4) begin araddr = ra[acc]; arid = ri[acc]; end
        else arvalid = 0;
      end
    end
    rready = 0; arvalid = 0;
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: beats=%0d, required 4", got);
    end else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (t[i] - t[i-1] !== LAT + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: %0d cycles between beats, required %0d", i, t[i] - t[i-1], LAT + 2);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] bad [2];
    logic [IDW-1:0] id, gid;
    logic [1:0] gresp;
    logic [127:0] d;
    logic last;
    bad[0] = BASE + 32'(16 * WORDS);
    bad[1] = BASE - 32'd16;
    for (int i = 0; i < 2; i++) begin
      id = IDW'($urandom);
      send_write(bad[i], id, rand128(), 16'hFFFF);
      get_b(gid, gresp);
      vectors++;
      if (gid !== id || gresp !== 2'b10) begin
        miscompares++;
        $display("FAIL oor_write%0d: bid=%h bresp=%b, required %h 10", i, gid, gresp, id);
      end
      id = IDW'($urandom);
      send_ar(bad[i], id);
      get_r(d, gid, gresp, last);
      vectors++;
      if (gid !== id || gresp !== 2'b10 || d !== '0) begin
        miscompares++;
        $display("FAIL oor_read%0d: rid=%h rresp=%b rdata=%h, required %h 10 0", i, gid, gresp, d, id);
      end
    end
    for (int i = 0; i < 2; i++) begin
      send_ar(BASE + 32'(16 * (i * (WORDS - 1))), 8'h11);
      get_r(d, gid, gresp, last);
      vectors++;
      if (d !== model_mem[i * (WORDS - 1)] || gresp !== 2'b00) begin
        miscompares++;
        $display("FAIL oor_unchanged w%0d: rdata=%h rresp=%b, required %h 00", i * (WORDS - 1), d, gresp, model_mem[i * (WORDS - 1)]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [IDW-1:0] id, gid;
    logic [1:0] gresp;
    logic [127:0] d, exp_d;
    logic [15:0] s;
    logic last;
    for (int op = 0; op < 40; op++) begin
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(0, 1) ? BASE + 32'(16 * WORDS) + 32'($urandom_range(0, 4095))
                                 : BASE - 32'd1 - 32'($urandom_range(0, 4095));
      else
        a = rand_addr();
      id = IDW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = rand128(); s = 16'($urandom);
        send_write(a, id, d, s);
        if (!addr_err(a)) model_mem[addr_idx(a)] = merge(model_mem[addr_idx(a)], d, s);
        get_b(gid, gresp);
        vectors++;
        if (gid !== id || gresp !== (addr_err(a) ? 2'b10 : 2'b00)) begin
          miscompares++;
          $display("FAIL rand_b op%0d addr %h: bid=%h bresp=%b, required %h %b", op, a, gid, gresp, id, addr_err(a) ? 2'b10 : 2'b00);
        end
      end else begin
        exp_d = expect_rdata(a);
        send_ar(a, id);
        get_r(d, gid, gresp, last);
        vectors++;
        if (gid !== id || gresp !== (addr_err(a) ? 2'b10 : 2'b00) || d !== exp_d || last !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_r op%0d addr %h: rid=%h rresp=%b rlast=%b rdata=%h, required %h %b 1 %h",
                   op, a, gid, gresp, last, d, id, addr_err(a) ? 2'b10 : 2'b00, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a;
    logic [IDW-1:0] gid;
    logic [1:0] gresp;
    logic [127:0] d;
    logic last;
    int n;
    rready = 0;
    for (int i = 0; i < 3; i++) send_ar(rand_addr(), IDW'(8'h60 + i));
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_rvalid: rvalid=%b, required 1", rvalid);
    end
    #2 reset_l = 0;
    #1;
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rvalid=%b during reset, required 0", rvalid);
    end
    @(negedge clk);
    reset_l = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || {arready, awready, wready} !== 3'b111) begin
        miscompares++;
        $display("FAIL post_reset c%0d: rvalid=%b bvalid=%b readies=%b, required 0 0 111", i, rvalid, bvalid, {arready, awready, wready});
      end
    end
    for (int i = 0; i < 4; i++) begin
      a = rand_addr();
      send_ar(a, IDW'(i));
      get_r(d, gid, gresp, last);
      vectors++;
      if (d !== model_mem[addr_idx(a)] || gid !== IDW'(i)) begin
        miscompares++;
        $display("FAIL retained%0d addr %h: rdata=%h rid=%h, required %h %h", i, a, d, gid, model_mem[addr_idx(a)], IDW'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_w_before_aw();
    test_read_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
